// File: rtl/subtractor8bit_serial_if.sv
// Operand/result bundle for the bit-serial 8-bit subtractor.
// Latency: n/a (wires only); the master drives start/a/b, the slave returns results.
// Backpressure: none; busy tells the master when start will be ignored.
interface subtractor8bit_serial_if;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       overflow;
    logic       busy;
    logic       done;

    modport master (
        output start, a, b,
        input  diff, borrow, overflow, busy, done
    );

    modport slave (
        input  start, a, b,
        output diff, borrow, overflow, busy, done
    );
endinterface

// File: rtl/subtractor8bit_serial.sv
// Bit-serial 8-bit subtractor diff = a - b, one bit per clock, LSB first, with a single full-subtractor cell.
// Latency: done pulses 8 cycles after the accepting edge, one op per 10 cycles.
// Backpressure: start is only accepted in IDLE (busy low); there is no queueing.
// Ports: clk, reset (async, active-high); bus.start/a/b in; bus.diff/borrow/overflow/busy/done out, all flop-driven.
module subtractor8bit_serial (
    input  logic                     clk,
    input  logic                     reset,
    subtractor8bit_serial_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t     state_q;
    logic [7:0] a_sh_q;
    logic [7:0] b_sh_q;
    logic [7:0] res_q;
    logic [2:0] cnt_q;
    logic       bin_q;
    logic [7:0] diff_q;
    logic       borrow_q;
    logic       overflow_q;
    logic       busy_q;
    logic       done_q;

    // Full-subtractor cell acting on the current operand LSBs.
    logic       a_bit;
    logic       b_bit;
    logic       d_bit;
    logic       bout;
    logic [7:0] res_d;

    always_comb begin
        a_bit = a_sh_q[0];
        b_bit = b_sh_q[0];
        d_bit = a_bit ^ b_bit ^ bin_q;
        bout  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin_q);
        // Result fills from the MSB side so bit 0 lands at res[0] after 8 shifts.
        res_d = {d_bit, res_q[7:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            a_sh_q     <= 8'h00;
            b_sh_q     <= 8'h00;
            res_q      <= 8'h00;
            cnt_q      <= 3'd0;
            bin_q      <= 1'b0;
            diff_q     <= 8'h00;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_sh_q  <= bus.a;
                        b_sh_q  <= bus.b;
                        cnt_q   <= 3'd0;
                        bin_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sh_q <= {1'b0, a_sh_q[7:1]};
                    b_sh_q <= {1'b0, b_sh_q[7:1]};
                    res_q  <= res_d;
                    bin_q  <= bout;
                    cnt_q  <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        // bin_q here is the borrow into the MSB; overflow is
                        // the carry-in/carry-out disagreement at the sign bit.
                        diff_q     <= res_d;
                        borrow_q   <= bout;
                        overflow_q <= bout ^ bin_q;
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.diff     = diff_q;
    assign bus.borrow   = borrow_q;
    assign bus.overflow = overflow_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_subtractor8bit_serial.sv
// Testbench for subtractor8bit_serial: scoreboard of expected results, monitor pops on done.
// Latency: checks the 8-cycle accept-to-done timing and the 10-cycle restart period.
// Backpressure: exercises start held high and start during busy.
module tb_subtractor8bit_serial;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    subtractor8bit_serial_if bus ();

    subtractor8bit_serial dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       b;
        logic       o;
    } exp_t;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
        logic       ov;
    } vec_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_diff;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: plain arithmetic definition of a - b.
    function automatic exp_t ref_sub(input logic [7:0] x, input logic [7:0] y);
        exp_t       r;
        logic [7:0] d;
        d   = x - y;
        r.d = d;
        r.b = (x < y);
        r.o = (x[7] != y[7]) && (d[7] != x[7]);
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b0 && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done diff=%0h with no outstanding op at %0t", bus.diff, $time);
            end else begin
                e = sb_q.pop_front();
                chk("diff", {24'h0, bus.diff}, {24'h0, e.d});
                chk("borrow", {31'h0, bus.borrow}, {31'h0, e.b});
                chk("overflow", {31'h0, bus.overflow}, {31'h0, e.o});
                chk("busy_in_done", {31'h0, bus.busy}, 32'h1);
            end
        end
    end

    // Waits for done after the accept negedge, checking diff holds meanwhile.
    task automatic wait_done(input logic [7:0] new_diff);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
            if (bus.done !== 1'b1)
                chk("diff_hold", {24'h0, bus.diff}, {24'h0, last_diff});
        end
        chk("latency", n, 8);
        last_diff = new_diff;
        @(negedge clk);
        chk("busy_after_done", {31'h0, bus.busy}, 32'h0);
        chk("done_after_done", {31'h0, bus.done}, 32'h0);
    endtask

    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input exp_t e);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        sb_q.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = ~x;
        bus.b     = x ^ y;
        chk("busy_after_accept", {31'h0, bus.busy}, 32'h1);
        chk("done_after_accept", {31'h0, bus.done}, 32'h0);
        wait_done(e.d);
    endtask

    vec_t       dir_vecs[4];
    logic [7:0] corners[10];

    initial begin
        exp_t e;
        dir_vecs[0] = '{a: 8'd100, b: 8'd58, d: 8'h2A, bo: 1'b0, ov: 1'b0};
        dir_vecs[1] = '{a: 8'h05,  b: 8'h0A, d: 8'hFB, bo: 1'b1, ov: 1'b0};
        dir_vecs[2] = '{a: 8'h80,  b: 8'h01, d: 8'h7F, bo: 1'b0, ov: 1'b1};
        dir_vecs[3] = '{a: 8'h7F,  b: 8'hFF, d: 8'h80, bo: 1'b1, ov: 1'b1};
        corners = '{8'h00, 8'h01, 8'h02, 8'h3F, 8'h40, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        last_diff = 8'h00;
        #12;
        chk("rst_diff", {24'h0, bus.diff}, 32'h0);
        chk("rst_borrow", {31'h0, bus.borrow}, 32'h0);
        chk("rst_overflow", {31'h0, bus.overflow}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_done", {31'h0, bus.done}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors with hand-computed results.
        foreach (dir_vecs[i])
            run_op(dir_vecs[i].a, dir_vecs[i].b,
                   '{d: dir_vecs[i].d, b: dir_vecs[i].bo, o: dir_vecs[i].ov});

        // start held high; operands change mid-SHIFT.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h03;
        sb_q.push_back('{d: 8'h0D, b: 1'b0, o: 1'b0});
        @(negedge clk);
        bus.a = 8'h03;
        bus.b = 8'h10;
        sb_q.push_back('{d: 8'hF3, b: 1'b1, o: 1'b0});
        chk("b2b_busy_first", {31'h0, bus.busy}, 32'h1);
        repeat (4) @(negedge clk);
        chk("b2b_diff_hold", {24'h0, bus.diff}, {24'h0, last_diff});
        repeat (4) @(negedge clk);
        chk("b2b_done_at_8", {31'h0, bus.done}, 32'h1);
        @(negedge clk);
        chk("b2b_idle_busy", {31'h0, bus.busy}, 32'h0);
        chk("b2b_idle_done", {31'h0, bus.done}, 32'h0);
        @(negedge clk);
        chk("b2b_second_accept", {31'h0, bus.busy}, 32'h1);
        bus.start = 1'b0;
        last_diff = 8'h0D;
        wait_done(8'hF3);

        // Reset in the middle of SHIFT (counter = 4): op discarded, no done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h3C;
        bus.b     = 8'h11;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_diff", {24'h0, bus.diff}, 32'h0);
        chk("mid_rst_borrow", {31'h0, bus.borrow}, 32'h0);
        chk("mid_rst_overflow", {31'h0, bus.overflow}, 32'h0);
        chk("mid_rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("mid_rst_done", {31'h0, bus.done}, 32'h0);
        last_diff = 8'h00;
        @(negedge clk);
        // Release with start already high: first rising edge must accept.
        reset     = 1'b0;
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
        sb_q.push_back('{d: 8'h00, b: 1'b0, o: 1'b0});
        @(negedge clk);
        bus.start = 1'b0;
        chk("post_rst_accept", {31'h0, bus.busy}, 32'h1);
        wait_done(8'h00);

        // Corner cross product plus pseudo-random pairs against the reference.
        foreach (corners[i])
            foreach (corners[j]) begin
                e = ref_sub(corners[i], corners[j]);
                run_op(corners[i], corners[j], e);
            end
        for (int k = 0; k < 600; k++) begin
            logic [7:0] x;
            logic [7:0] y;
            x = 8'($urandom_range(0, 255));
            y = 8'($urandom_range(0, 255));
            e = ref_sub(x, y);
            run_op(x, y, e);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
